pipelined_ripple_adder: RTL and testbench
=========================================

Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the combinational 4-bit ripple-carry adder.
- Splits a DATA_WIDTH carry chain into STAGE_WIDTH-bit slices with one register stage per slice.
- Adds add/subtract mode, signed-overflow flag and valid/ready handshakes on both sides with full backpressure.
- Used as the datapath adder in stream arithmetic units where a long ripple chain would break timing.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; must be >= 1.
- STAGE_WIDTH, 8, carry-chain bits resolved per pipeline stage; range 1..DATA_WIDTH.
- N_STAGES (derived, localparam), ceil(DATA_WIDTH/STAGE_WIDTH), pipeline depth; the last slice may be narrower.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b.
- in_ci  in  1  carry in; ignored when in_sub=1.
- in_sub  in  1  0: a+b+ci; 1: a-b, computed as a+~b+1.
- in_vld  in  1  input valid.
- in_rd  out  1  input ready.
- out_s  out  DATA_WIDTH  sum/difference.
- out_co  out  1  carry out; for subtract, 1 = no borrow.
- out_ovf  out  1  two's-complement signed overflow.
- out_vld  out  1  output valid.
- out_rd  in  1  output ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear, so out_vld=0.
  - out_s=0, out_co=0, out_ovf=0.
  - in_rd is high as soon as the pipeline is empty.
  - Data registers also reset to 0, with no X propagation.
  - Reset mid-operation discards all in-flight items; no output appears for them.
- Transfers:
  - Input transfer occurs when in_vld and in_rd are both high.
  - Output transfer occurs when out_vld and out_rd are both high.
  - Inputs must hold stable while in_vld=1 and in_rd=0.
- Stage k (0..N_STAGES-1):
  - Holds vld[k], the carry out of slice k, the result bits for slices 0..k, and the still-unprocessed operand bits for slices k+1..N_STAGES-1.
  - Stage 0 computes slice 0 from the inputs.
  - Stage k>0 computes slice k from the stage k-1 registers and carry.
  - Only the operand bits for slices not yet summed are carried forward.
- Subtract mode:
  - ~b and carry-in = 1 are applied at the input, before stage 0 registers.
  - The mode bit itself is not piped.
- Advance rule:
  - adv[N-1] = !vld[N-1] || out_rd.
  - adv[k] = !vld[k] || adv[k+1].
  - in_rd = adv[0].
  - When adv[k] is high: vld[k] <= vld[k-1] (in_vld for k=0) and the data registers load. Otherwise the stage holds.
  - The ready chain is combinational from out_rd to in_rd. This is accepted as a known timing path; no skid buffer.
- Latency and throughput:
  - Latency is exactly N_STAGES cycles from input transfer to out_vld, with no stalls.
  - Throughput is 1 item/cycle while out_rd=1.
- Bubbles: internal empty stages collapse under backpressure. The pipeline holds up to N_STAGES items, in order, with none lost or duplicated.
- Outputs:
  - out_s, out_co and out_ovf are driven directly from the last stage registers.
  - They are stable while out_vld=1 and out_rd=0.
- Overflow: out_ovf = carry into the MSB XOR carry out of the MSB. It is computed in the last stage, which owns the MSB.
- Narrow last slice: it covers bits (N_STAGES-1)*STAGE_WIDTH .. DATA_WIDTH-1.
- N_STAGES=1: degenerates to a single registered adder with the same handshake.

Decomposition:
- Shared package (adder_pkg):
  - n_stages(DATA_WIDTH, STAGE_WIDTH) ceil-div function.
  - slice_lo(k) and slice_w(k) bounds functions.
  - ADD/SUB mode encoding constants.
- One sub-module, carry_slice (parameter W):
  - Combinational W-bit ripple of per-bit full adders.
  - Outputs s, co, and the carry into the MSB (for overflow).
  - Instantiated once per stage via generate.

Test Plan:
- DATA_WIDTH=8, STAGE_WIDTH=4, out_rd=1: a=0xFF, b=0x01, ci=0, add -> after exactly 2 cycles s=0x00, co=1, ovf=0.
- Same configuration: a=0x7F, b=0x01, add -> s=0x80, co=0, ovf=1. Then a=0x05, b=0x07, sub -> s=0xFE, co=0, ovf=0.
- Back-to-back stream of 16 random items with out_rd=1 -> one result per cycle, in order, matching a+b+ci mod 2^8; in_rd never drops.
- Backpressure: out_rd=0 while 4 items are offered -> in_rd falls after 2 items are accepted. Release out_rd -> all items emerge in order with no loss or duplication, and out_s is stable while stalled.
- Reset mid-stream: assert rst_n=0 with 2 items in flight -> out_vld=0 and out_s=0 immediately (asynchronous). After release, the next input alone emerges after 2 cycles.
- DATA_WIDTH=10, STAGE_WIDTH=4 (3 stages, last slice 2 bits): a=0x3FF, b=0x001, ci=1 -> after 3 cycles s=0x001, co=1. Signed a=0x200, b=0x3FF, add -> s=0x1FF, ovf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: mode encoding and
// slice geometry helpers used to split the carry chain across pipeline stages.
package adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int unsigned n_stages(input int unsigned dw, input int unsigned sw);
        return (dw + sw - 1) / sw;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned sw);
        return k * sw;
    endfunction

    // The final slice may be narrower than sw when dw is not a multiple of it.
    function automatic int unsigned slice_w(input int unsigned k, input int unsigned dw,
                                            input int unsigned sw);
        int unsigned lo;
        lo = k * sw;
        return (dw - lo < sw) ? (dw - lo) : sw;
    endfunction

endpackage

// File: rtl/carry_slice.sv
// Combinational W-bit ripple of full adders; also exposes the carry into the
// MSB so the owner of the top bit can derive signed overflow.
module carry_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic carry;

    always_comb begin
        carry = ci;
        c_msb = 1'b0;
        s     = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i == W - 1) begin
                c_msb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: one carry slice per register stage, valid/ready on
// both sides with full backpressure and bubble collapsing.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STAGE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_ci,
    input  logic                  in_sub,
    input  logic                  in_vld,
    output logic                  in_rd,
    output logic [DATA_WIDTH-1:0] out_s,
    output logic                  out_co,
    output logic                  out_ovf,
    output logic                  out_vld,
    input  logic                  out_rd
);

    localparam int unsigned N_STAGES = n_stages(DATA_WIDTH, STAGE_WIDTH);

    // acc holds finished result bits below the current slice and untouched
    // operand-a bits above it, so one vector carries both forward.
    logic [DATA_WIDTH-1:0] acc_q [N_STAGES];
    logic [DATA_WIDTH-1:0] b_q   [N_STAGES];
    logic [DATA_WIDTH-1:0] s_src [N_STAGES];
    logic [DATA_WIDTH-1:0] b_src [N_STAGES];
    logic [DATA_WIDTH-1:0] acc_d [N_STAGES];
    logic                  ovf_d [N_STAGES];
    logic [N_STAGES-1:0]   vld;
    logic [N_STAGES-1:0]   adv;
    logic [N_STAGES-1:0]   vld_src;
    logic [N_STAGES-1:0]   carry_q;
    logic [N_STAGES-1:0]   c_src;
    logic [N_STAGES-1:0]   co_w;
    logic                  ovf_q;

    // A stage may advance unless it and every stage downstream is full and
    // the sink is stalled; evaluated per stage to avoid a self-referencing chain.
    always_comb begin : ready_chain
        logic full;
        full = 1'b1;
        adv  = '0;
        for (int unsigned j = 0; j < N_STAGES; j++) begin
            full                  = full & vld[N_STAGES-1-j];
            adv[N_STAGES-1-j]     = !full || out_rd;
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        localparam int unsigned LO = slice_lo(k, STAGE_WIDTH);
        localparam int unsigned W  = slice_w(k, DATA_WIDTH, STAGE_WIDTH);
        localparam logic [DATA_WIDTH-1:0] MASK = DATA_WIDTH'({W{1'b1}}) << LO;

        logic [W-1:0] s_sl;
        logic         c_msb;

        if (k == 0) begin : g_first
            assign vld_src[k] = in_vld;
            assign s_src[k]   = in_a;
            assign b_src[k]   = (in_sub == MODE_SUB) ? ~in_b : in_b;
            assign c_src[k]   = (in_sub == MODE_SUB) ? 1'b1 : in_ci;
        end else begin : g_next
            assign vld_src[k] = vld[k-1];
            assign s_src[k]   = acc_q[k-1];
            assign b_src[k]   = b_q[k-1];
            assign c_src[k]   = carry_q[k-1];
        end

        carry_slice #(.W(W)) u_slice (
            .a     (s_src[k][LO +: W]),
            .b     (b_src[k][LO +: W]),
            .ci    (c_src[k]),
            .s     (s_sl),
            .co    (co_w[k]),
            .c_msb (c_msb)
        );

        assign acc_d[k] = (s_src[k] & ~MASK) | (DATA_WIDTH'(s_sl) << LO);
        assign ovf_d[k] = c_msb ^ co_w[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                acc_q[k] <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                if (adv[k]) begin
                    vld[k]     <= vld_src[k];
                    acc_q[k]   <= acc_d[k];
                    b_q[k]     <= b_src[k];
                    carry_q[k] <= co_w[k];
                end
            end
            if (adv[N_STAGES-1]) begin
                ovf_q <= ovf_d[N_STAGES-1];
            end
        end
    end

    assign in_rd   = adv[0];
    assign out_vld = vld[N_STAGES-1];
    assign out_s   = acc_q[N_STAGES-1];
    assign out_co  = carry_q[N_STAGES-1];
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed self-checking bench: an 8-bit/4-bit (2-stage) instance and a
// 10-bit/4-bit (3-stage, narrow last slice) instance sharing clock and reset.
module tb_pipelined_ripple_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0] a_a, a_b, a_s;
    logic       a_ci, a_sub, a_ivld, a_ird, a_co, a_ovf, a_ovld, a_ord;

    logic [9:0] b_a, b_b, b_s;
    logic       b_ci, b_sub, b_ivld, b_ird, b_co, b_ovf, b_ovld, b_ord;

    pipelined_ripple_adder #(.DATA_WIDTH(8), .STAGE_WIDTH(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_a(a_a), .in_b(a_b), .in_ci(a_ci), .in_sub(a_sub),
        .in_vld(a_ivld), .in_rd(a_ird),
        .out_s(a_s), .out_co(a_co), .out_ovf(a_ovf),
        .out_vld(a_ovld), .out_rd(a_ord)
    );

    pipelined_ripple_adder #(.DATA_WIDTH(10), .STAGE_WIDTH(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n),
        .in_a(b_a), .in_b(b_b), .in_ci(b_ci), .in_sub(b_sub),
        .in_vld(b_ivld), .in_rd(b_ird),
        .out_s(b_s), .out_co(b_co), .out_ovf(b_ovf),
        .out_vld(b_ovld), .out_rd(b_ord)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] q [$];
    logic [9:0] exp_v;
    logic [7:0] bp_a [4] = '{8'h10, 8'h30, 8'hF0, 8'h88};
    logic [7:0] bp_b [4] = '{8'h20, 8'h40, 8'h20, 8'h88};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, co, s} for the 8-bit instance using sign-bit comparison.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic sub);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] sum;
        logic       ovf;
        bb  = sub ? ~b : b;
        cc  = sub ? 1'b1 : ci;
        sum = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
        ovf = (a[7] == bb[7]) && (sum[7] != a[7]);
        return {ovf, sum};
    endfunction

    task automatic drive_a(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           input logic sub, input logic vld);
        a_a = a; a_b = b; a_ci = ci; a_sub = sub; a_ivld = vld;
    endtask

    task automatic drive_b(input logic [9:0] a, input logic [9:0] b, input logic ci,
                           input logic sub, input logic vld);
        b_a = a; b_b = b; b_ci = ci; b_sub = sub; b_ivld = vld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int   idx;
        int   rcv;
        logic acc;
        logic [7:0] ra, rb;
        logic       rc;

        rst_n = 1'b0;
        drive_a(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive_b(10'h000, 10'h000, 1'b0, 1'b0, 1'b0);
        a_ord = 1'b1;
        b_ord = 1'b1;
        #1;
        chk("rst_vld",   a_ovld, 0);
        chk("rst_s",     a_s,    0);
        chk("rst_co",    a_co,   0);
        chk("rst_ovf",   a_ovf,  0);
        chk("rst_in_rd", a_ird,  1);
        chk("rst_vld10", b_ovld, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 0xFF + 0x01: wraps with carry, two-cycle latency
        drive_a(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a_ivld = 1'b0;
        chk("t1_lat1_vld", a_ovld, 0);
        @(negedge clk);
        chk("t1_vld", a_ovld, 1);
        chk("t1_s",   a_s,    8'h00);
        chk("t1_co",  a_co,   1);
        chk("t1_ovf", a_ovf,  0);
        @(negedge clk);
        chk("t1_drain", a_ovld, 0);

        // 0x7F + 0x01 then 0x05 - 0x07 (ci=1 must be ignored in subtract)
        drive_a(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_a(8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        a_ivld = 1'b0;
        chk("t2_vld", a_ovld, 1);
        chk("t2_s",   a_s,    8'h80);
        chk("t2_co",  a_co,   0);
        chk("t2_ovf", a_ovf,  1);
        @(negedge clk);
        chk("t3_vld", a_ovld, 1);
        chk("t3_s",   a_s,    8'hFE);
        chk("t3_co",  a_co,   0);
        chk("t3_ovf", a_ovf,  0);
        @(negedge clk);

        // Back-to-back stream of 16 random additions
        for (int i = 0; i < 18; i++) begin
            chk("stream_vld", a_ovld, (i >= 2) ? 1 : 0);
            if (a_ovld && q.size() != 0) begin
                exp_v = q.pop_front();
                chk("stream_s",   a_s,   exp_v[7:0]);
                chk("stream_co",  a_co,  exp_v[8]);
                chk("stream_ovf", a_ovf, exp_v[9]);
            end
            if (i < 16) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));
                drive_a(ra, rb, rc, 1'b0, 1'b1);
                q.push_back(model8(ra, rb, rc, 1'b0));
                #1;
                chk("stream_in_rd", a_ird, 1);
            end else begin
                a_ivld = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_q_empty", q.size(), 0);
        chk("stream_idle", a_ovld, 0);

        // Backpressure: sink stalled while 4 items are offered
        a_ord = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive_a(bp_a[idx], bp_b[idx], 1'b0, 1'b0, 1'b1);
            #1;
            acc = a_ird;
            if (cyc == 2) chk("bp_in_rd_low", a_ird, 0);
            @(negedge clk);
            if (acc) begin
                q.push_back(model8(bp_a[idx], bp_b[idx], 1'b0, 1'b0));
                idx++;
            end
            if (cyc >= 1) begin
                chk("bp_hold_vld", a_ovld, 1);
                chk("bp_hold_s",   a_s,    8'h30);
            end
        end
        chk("bp_accepted", idx, 2);

        a_ord = 1'b1;
        rcv = 0;
        for (int cyc = 0; cyc < 12 && rcv < 4; cyc++) begin
            if (a_ovld) begin
                if (q.size() != 0) begin
                    exp_v = q.pop_front();
                    chk("bp_s",  a_s,  exp_v[7:0]);
                    chk("bp_co", a_co, exp_v[8]);
                end
                rcv++;
            end
            if (idx < 4) drive_a(bp_a[idx], bp_b[idx], 1'b0, 1'b0, 1'b1);
            else         a_ivld = 1'b0;
            #1;
            acc = a_ird;
            @(negedge clk);
            if (idx < 4 && a_ivld && acc) begin
                q.push_back(model8(bp_a[idx], bp_b[idx], 1'b0, 1'b0));
                idx++;
            end
        end
        a_ivld = 1'b0;
        chk("bp_rcv", rcv, 4);
        chk("bp_q_empty", q.size(), 0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            chk("bp_no_dup", a_ovld, 0);
            @(negedge clk);
        end

        // Reset with two items in flight
        drive_a(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_a(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a_ivld = 1'b0;
        chk("mr_pre_vld", a_ovld, 1);
        chk("mr_pre_s",   a_s,    8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_vld",   a_ovld, 0);
        chk("mr_s",     a_s,    0);
        chk("mr_in_rd", a_ird,  1);
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a_ivld = 1'b0;
        chk("mr_post_lat1", a_ovld, 0);
        @(negedge clk);
        chk("mr_post_vld", a_ovld, 1);
        chk("mr_post_s",   a_s,    8'h33);
        @(negedge clk);
        chk("mr_post_alone", a_ovld, 0);

        // 10-bit / 3-stage instance
        drive_b(10'h3FF, 10'h001, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        b_ivld = 1'b0;
        chk("w10_lat1", b_ovld, 0);
        @(negedge clk);
        chk("w10_lat2", b_ovld, 0);
        @(negedge clk);
        chk("w10_vld", b_ovld, 1);
        chk("w10_s",   b_s,    10'h001);
        chk("w10_co",  b_co,   1);
        chk("w10_ovf", b_ovf,  0);

        drive_b(10'h200, 10'h3FF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_b(10'h000, 10'h001, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        b_ivld = 1'b0;
        @(negedge clk);
        chk("w10_ovf_vld", b_ovld, 1);
        chk("w10_ovf_s",   b_s,    10'h1FF);
        chk("w10_ovf_co",  b_co,   1);
        chk("w10_ovf_ovf", b_ovf,  1);
        @(negedge clk);
        chk("w10_sub_vld", b_ovld, 1);
        chk("w10_sub_s",   b_s,    10'h3FF);
        chk("w10_sub_co",  b_co,   0);
        chk("w10_sub_ovf", b_ovf,  0);
        @(negedge clk);
        chk("w10_idle", b_ovld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
